trig_link_tx: RTL and testbench
===============================

# trig_link_tx

Transmit end of the coax trigger link: each readout board turns its local discriminator hits into clean, fixed-length, active-low pulses on its coax trigger outputs. The trigger board samples these lines with inverting, coincidence-window receivers. The block enforces pulse width and per-channel holdoff, so the receiver sees one edge per hit. It also drives a level busy line that the receiver uses as a veto, and optionally keeps sent/dropped counters for monitoring.

## Interface
- NCH, 16, number of coax trigger channels driven
- CW, 32, width of monitoring counters
- clk_adc  in  1  sampling clock, same domain as hits
- nrst  in  1  asynchronous, active-low reset
- hit  in  NCH  per-channel hit request, level, sampled each edge
- chanmask  in  NCH  1 = channel enabled; masked channels never pulse and never count
- pulse_len  in  8  pulse width in clk_adc cycles; 0 treated as 1
- holdoff  in  8  dead cycles after a pulse ends; 0 = none
- busy_in  in  1  local readout busy; inhibits new pulses on all channels
- coax_out  out  NCH  trigger lines, active-low (idle 1)
- busy_out  out  1  busy line to trigger board, active-low (idle 1)
- tx_active  out  NCH  1 while channel is in PULSE or HOLDOFF
- cnt_sel  in  $clog2(NCH)  channel selected for counter readout
- cnt_clear  in  1  synchronous clear of all counters
- sent_out  out  CW  pulses sent on selected channel
- drop_out  out  CW  hits dropped on selected channel

## Operation
- Per-channel FSM:
  - IDLE: on hit_q & chanmask & !busy_q, go to PULSE and load the down-counter with max(pulse_len,1).
  - PULSE: counter decrements each cycle. When the counter reaches 1, go to HOLDOFF and load holdoff, or go to IDLE if holdoff==0.
  - HOLDOFF: counter decrements. Return to IDLE when the counter reaches 1.
- hit_q and busy_q are input registers. hit is level-sensitive: a hit still held high on return to IDLE starts a new pulse.
- pulse_len and holdoff are sampled only when the corresponding state is entered. Changes mid-pulse take effect on the next pulse.
- Drops: a hit_q seen while the channel is not in IDLE, or while busy_q blocks it, increments that channel's drop counter, counted once per rising edge of hit_q.
- Masking: clearing chanmask mid-pulse does not truncate the current pulse. It only blocks new pulses.
- Busy: busy_out = ~busy_q.
- Counters saturate at all-ones. cnt_clear wins over a simultaneous increment.
- Reset: all FSMs go to IDLE and all counters to 0. Reset values are coax_out all 1, busy_out 1, tx_active 0, sent_out 0, drop_out 0. Reset asserted mid-pulse returns lines to idle immediately (async).

## Timing
- hit first high at edge k gives hit_q at k. The FSM enters PULSE at k+1. coax_out goes low after edge k+2 and stays low for exactly max(pulse_len,1) cycles.
- Minimum spacing between falling edges on one channel is max(pulse_len,1)+holdoff+1 cycles.
- busy_in to busy_out latency is 2 edges. Busy inhibits a hit_q sampled on the same edge.
- tx_active is registered and aligned with coax_out.
- Counter readout: sent_out/drop_out are registered, with 1-cycle latency from cnt_sel. An increment is visible on the cycle after the state transition.

## Configuration
- TRIG_LINK_TX_COUNTERS_EN:
  - Defined: sent/drop counters, cnt_clear and readout mux are built.
  - Undefined: no counter registers; sent_out and drop_out are tied to 0; cnt_sel and cnt_clear are ignored.
- Pulse and FSM behaviour are identical either way.

## Structure
- The shared package trig_link_pkg holds:
  - the state enum (IDLE, PULSE, HOLDOFF)
  - the LINK_IDLE=1'b1 line-level constant
  - default NCH/CW
- The receiver side uses the same idle level.
- Sub-module trig_link_tx_chan holds one FSM, its down-counter, output flop and optional counters. The top holds the input registers, busy path and readout mux.

## Test plan
- Single pulse: pulse_len=4, holdoff=0, 1-cycle hit on ch3 at edge 10 -> coax_out[3] low during cycles 12–15, sent=1 on ch3 only.
- pulse_len=0: one hit -> exactly 1-cycle low pulse.
- Holdoff drop: pulse_len=4, holdoff=6, hits on ch0 at edges 10 and 14 -> one pulse, drop=1. A third hit at edge 22 -> second pulse starts at edge 24.
- Busy/mask:
  - busy_in high, hits on all channels -> no pulses, drop=1 each, busy_out low 2 cycles after busy_in.
  - chanmask[5]=0 -> ch5 silent with no counts.
- Counters: force sent to all-ones then hit -> stays all-ones. cnt_clear concurrent with a hit -> counter reads 0.
- Reset mid-pulse: nrst low during pulse -> coax_out all 1 immediately. After release, the first hit pulses normally.

Source files
------------

// File: rtl/trig_link_tx_pkg.sv
// Shared coax trigger link definitions: idle line level, per-channel FSM states, default sizing.
// The receiver side imports the same package so both ends agree on the idle level.
package trig_link_pkg;

  localparam int NCH_DEF = 16;
  localparam int CW_DEF  = 32;

  localparam logic LINK_IDLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    HOLDOFF = 2'd2
  } link_state_e;

  // A zero pulse length still produces a one-cycle pulse.
  function automatic logic [7:0] eff_len(input logic [7:0] len);
    return (len == 8'd0) ? 8'd1 : len;
  endfunction

endpackage

// File: rtl/trig_link_tx_if.sv
// Coax trigger link bundle: hit/mask/busy requests in, active-low lines and busy/activity status out.
// No backpressure: busy_in is a level veto on new pulses, not a handshake.
interface trig_link_tx_if #(
  parameter int NCH = 16
);

  logic [NCH-1:0] hit;
  logic [NCH-1:0] chanmask;
  logic           busy_in;
  logic [NCH-1:0] coax_out;
  logic           busy_out;
  logic [NCH-1:0] tx_active;

  modport master (
    output hit, chanmask, busy_in,
    input  coax_out, busy_out, tx_active
  );

  modport slave (
    input  hit, chanmask, busy_in,
    output coax_out, busy_out, tx_active
  );

endinterface

// File: rtl/trig_link_tx_chan.sv
// One trigger channel: IDLE/PULSE/HOLDOFF FSM, line low 2 edges after hit_q for max(pulse_len,1) cycles.
// No backpressure; hits arriving outside IDLE or under busy are dropped (counted if TRIG_LINK_TX_COUNTERS_EN).
module trig_link_tx_chan
  import trig_link_pkg::*;
`ifdef TRIG_LINK_TX_COUNTERS_EN
#(
  parameter int CW = CW_DEF
)
`endif
(
  input  logic          clk_adc,
  input  logic          nrst,
  input  logic          hit_q,
  input  logic          chan_en,
  input  logic          busy_q,
  input  logic [7:0]    pulse_len,
  input  logic [7:0]    holdoff,
`ifdef TRIG_LINK_TX_COUNTERS_EN
  input  logic          cnt_clear,
  output logic [CW-1:0] sent_cnt,
  output logic [CW-1:0] drop_cnt,
`endif
  output logic          coax_o,
  output logic          tx_active_o
);

  link_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        coax_q, coax_d;
  logic        act_q, act_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (hit_q && chan_en && !busy_q) begin
          state_d = PULSE;
          cnt_d   = eff_len(pulse_len);
        end
      end
      PULSE: begin
        // Mask is deliberately ignored here so a running pulse is never truncated.
        if (cnt_q > 8'd1) begin
          cnt_d = cnt_q - 8'd1;
        end else if (holdoff == 8'd0) begin
          state_d = IDLE;
        end else begin
          state_d = HOLDOFF;
          cnt_d   = holdoff;
        end
      end
      HOLDOFF: begin
        if (cnt_q > 8'd1) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    coax_d = (state_q == PULSE) ? ~LINK_IDLE : LINK_IDLE;
    act_d  = (state_q != IDLE);
  end

  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      coax_q  <= LINK_IDLE;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      coax_q  <= coax_d;
      act_q   <= act_d;
    end
  end

  assign coax_o      = coax_q;
  assign tx_active_o = act_q;

`ifdef TRIG_LINK_TX_COUNTERS_EN
  logic          hit_prev_q, hit_prev_d;
  logic [CW-1:0] sent_q, sent_d;
  logic [CW-1:0] drop_q, drop_d;
  logic          start_ev;
  logic          drop_ev;

  assign start_ev = (state_q == IDLE) && (state_d == PULSE);
  // One drop per rising edge of hit_q, so a held level is not counted every cycle.
  assign drop_ev  = hit_q && !hit_prev_q && chan_en && ((state_q != IDLE) || busy_q);

  always_comb begin
    hit_prev_d = hit_q;
    sent_d     = sent_q;
    drop_d     = drop_q;
    if (cnt_clear) begin
      sent_d = '0;
      drop_d = '0;
    end else begin
      if (start_ev && !(&sent_q)) sent_d = sent_q + 1'b1;
      if (drop_ev && !(&drop_q))  drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      hit_prev_q <= 1'b0;
      sent_q     <= '0;
      drop_q     <= '0;
    end else begin
      hit_prev_q <= hit_prev_d;
      sent_q     <= sent_d;
      drop_q     <= drop_d;
    end
  end

  assign sent_cnt = sent_q;
  assign drop_cnt = drop_q;
`endif

endmodule

// File: rtl/trig_link_tx.sv
// Coax trigger link transmitter: registered hit/busy inputs, NCH channel FSMs, busy line, counter readout.
// Hit-to-line latency 2 edges, busy 2 edges; no backpressure. Counters built only with TRIG_LINK_TX_COUNTERS_EN.
module trig_link_tx
  import trig_link_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int CW  = CW_DEF
)
(
  input  logic                   clk_adc,
  input  logic                   nrst,
  trig_link_tx_if.slave          lnk,
  input  logic [7:0]             pulse_len,
  input  logic [7:0]             holdoff,
  input  logic [$clog2(NCH)-1:0] cnt_sel,
  input  logic                   cnt_clear,
  output logic [CW-1:0]          sent_out,
  output logic [CW-1:0]          drop_out
);

  logic [NCH-1:0] hit_q, hit_d;
  logic           busy_q, busy_d;
  logic           busy_out_q, busy_out_d;
  logic [NCH-1:0] coax;
  logic [NCH-1:0] act;

  always_comb begin
    hit_d      = lnk.hit;
    busy_d     = lnk.busy_in;
    busy_out_d = ~busy_q;
  end

  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      hit_q      <= '0;
      busy_q     <= 1'b0;
      busy_out_q <= LINK_IDLE;
    end else begin
      hit_q      <= hit_d;
      busy_q     <= busy_d;
      busy_out_q <= busy_out_d;
    end
  end

  assign lnk.busy_out  = busy_out_q;
  assign lnk.coax_out  = coax;
  assign lnk.tx_active = act;

`ifdef TRIG_LINK_TX_COUNTERS_EN
  logic [CW-1:0] sent_arr [NCH];
  logic [CW-1:0] drop_arr [NCH];
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    trig_link_tx_chan
`ifdef TRIG_LINK_TX_COUNTERS_EN
      #(.CW(CW))
`endif
      u_chan (
        .clk_adc     (clk_adc),
        .nrst        (nrst),
        .hit_q       (hit_q[i]),
        .chan_en     (lnk.chanmask[i]),
        .busy_q      (busy_q),
        .pulse_len   (pulse_len),
        .holdoff     (holdoff),
`ifdef TRIG_LINK_TX_COUNTERS_EN
        .cnt_clear   (cnt_clear),
        .sent_cnt    (sent_arr[i]),
        .drop_cnt    (drop_arr[i]),
`endif
        .coax_o      (coax[i]),
        .tx_active_o (act[i])
      );
  end

`ifdef TRIG_LINK_TX_COUNTERS_EN
  logic [CW-1:0] sent_out_q, sent_out_d;
  logic [CW-1:0] drop_out_q, drop_out_d;

  always_comb begin
    sent_out_d = sent_arr[cnt_sel];
    drop_out_d = drop_arr[cnt_sel];
  end

  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      sent_out_q <= '0;
      drop_out_q <= '0;
    end else begin
      sent_out_q <= sent_out_d;
      drop_out_q <= drop_out_d;
    end
  end

  assign sent_out = sent_out_q;
  assign drop_out = drop_out_q;
`else
  logic unused_cnt_ctrl;
  assign unused_cnt_ctrl = ^{cnt_sel, cnt_clear};
  assign sent_out = '0;
  assign drop_out = '0;
`endif

endmodule

// File: tb/tb_trig_link_tx.sv
// Directed bench for trig_link_tx: pulse shape, holdoff, busy, mask, counters and async reset.
// Counter expectations collapse to zero when TRIG_LINK_TX_COUNTERS_EN is not defined.
module tb_trig_link_tx;

  localparam int NCH = 16;
  localparam int CW  = 4;
`ifdef TRIG_LINK_TX_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk_adc = 1'b0;
  logic          nrst;
  logic [7:0]    pulse_len;
  logic [7:0]    holdoff;
  logic [3:0]    cnt_sel;
  logic          cnt_clear;
  logic [CW-1:0] sent_out;
  logic [CW-1:0] drop_out;

  int n_tests = 0;
  int n_fail  = 0;

  trig_link_tx_if #(.NCH(NCH)) lnk();

  trig_link_tx #(.NCH(NCH), .CW(CW)) dut (
    .clk_adc   (clk_adc),
    .nrst      (nrst),
    .lnk       (lnk),
    .pulse_len (pulse_len),
    .holdoff   (holdoff),
    .cnt_sel   (cnt_sel),
    .cnt_clear (cnt_clear),
    .sent_out  (sent_out),
    .drop_out  (drop_out)
  );

  always #5 clk_adc = ~clk_adc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cexp(input int v);
    return CNT_EN ? v : 0;
  endfunction

  task automatic tick();
    @(posedge clk_adc);
    #1;
  endtask

  task automatic clear_cnt();
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
  endtask

  task automatic read_cnt(input int ch, output logic [CW-1:0] s, output logic [CW-1:0] d);
    cnt_sel = ch[3:0];
    tick();
    tick();
    s = sent_out;
    d = drop_out;
  endtask

  // Drive hit[ch] = pat[i] into edge i (i = 1..n) and measure the line after each edge.
  task automatic probe(input int ch, input logic [63:0] pat, input int n,
                       output int first_fall, output int second_fall,
                       output int falls, output int lows, output int acts);
    logic prev;
    prev = 1'b1;
    first_fall = 0; second_fall = 0; falls = 0; lows = 0; acts = 0;
    for (int i = 1; i <= n; i++) begin
      lnk.hit[ch] = pat[i];
      tick();
      if (lnk.coax_out[ch] == 1'b0) begin
        lows++;
        if (prev) begin
          falls++;
          if (falls == 1) first_fall = i;
          if (falls == 2) second_fall = i;
        end
      end
      if (lnk.tx_active[ch]) acts++;
      prev = lnk.coax_out[ch];
    end
    lnk.hit[ch] = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ff, sf, nf, lw, ac;
    logic [CW-1:0] s, d;
    logic [NCH-1:0] low_seen;

    nrst = 1'b0;
    lnk.hit = '0;
    lnk.chanmask = '1;
    lnk.busy_in = 1'b0;
    pulse_len = 8'd4;
    holdoff = 8'd0;
    cnt_sel = 4'd0;
    cnt_clear = 1'b0;
    tick();
    tick();
    check("rst_coax", lnk.coax_out, 16'hFFFF);
    check("rst_busy_out", lnk.busy_out, 1);
    check("rst_tx_active", lnk.tx_active, 0);
    check("rst_sent", sent_out, 0);
    check("rst_drop", drop_out, 0);
    nrst = 1'b1;
    tick();

    // Single 1-cycle hit on ch3, pulse_len 4, no holdoff.
    probe(3, 64'h2, 12, ff, sf, nf, lw, ac);
    check("single_first_fall", ff, 3);
    check("single_low_cycles", lw, 4);
    check("single_falls", nf, 1);
    check("single_tx_active", ac, 4);
    read_cnt(3, s, d);
    check("single_sent_ch3", s, cexp(1));
    check("single_drop_ch3", d, 0);
    read_cnt(2, s, d);
    check("single_sent_ch2", s, 0);

    // pulse_len 0 behaves as 1.
    pulse_len = 8'd0;
    probe(1, 64'h2, 6, ff, sf, nf, lw, ac);
    check("len0_first_fall", ff, 3);
    check("len0_low_cycles", lw, 1);

    // Holdoff: hits at 1, 5, 13; the one at 5 lands in PULSE and is dropped.
    clear_cnt();
    pulse_len = 8'd4;
    holdoff = 8'd6;
    probe(0, 64'h2022, 26, ff, sf, nf, lw, ac);
    check("hold_first_fall", ff, 3);
    check("hold_second_fall", sf, 15);
    check("hold_falls", nf, 2);
    check("hold_low_cycles", lw, 8);
    check("hold_tx_active", ac, 20);
    read_cnt(0, s, d);
    check("hold_sent_ch0", s, cexp(2));
    check("hold_drop_ch0", d, cexp(1));

    // Busy veto on all channels.
    clear_cnt();
    holdoff = 8'd0;
    lnk.busy_in = 1'b1;
    tick();
    check("busy_out_after_1", lnk.busy_out, 1);
    tick();
    check("busy_out_after_2", lnk.busy_out, 0);
    low_seen = '0;
    lnk.hit = '1;
    tick();
    low_seen |= ~lnk.coax_out;
    lnk.hit = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      low_seen |= ~lnk.coax_out;
    end
    check("busy_no_pulse", low_seen, 0);
    read_cnt(0, s, d);
    check("busy_drop_ch0", d, cexp(1));
    check("busy_sent_ch0", s, 0);
    read_cnt(15, s, d);
    check("busy_drop_ch15", d, cexp(1));
    lnk.busy_in = 1'b0;
    tick();
    check("busy_release_1", lnk.busy_out, 0);
    tick();
    check("busy_release_2", lnk.busy_out, 1);

    // Masked channel stays silent and does not count.
    clear_cnt();
    lnk.chanmask = 16'hFFDF;
    probe(5, 64'h2, 8, ff, sf, nf, lw, ac);
    check("mask_low_cycles", lw, 0);
    read_cnt(5, s, d);
    check("mask_sent_ch5", s, 0);
    check("mask_drop_ch5", d, 0);
    lnk.chanmask = '1;

    // Held hit with pulse_len 1: pulses every 2 cycles, sent saturates.
    pulse_len = 8'd1;
    probe(2, 64'h1FF_FFFF_FFFE, 40, ff, sf, nf, lw, ac);
    check("sat_falls", nf, 19);
    check("sat_second_fall", sf, 5);
    read_cnt(2, s, d);
    check("sat_sent_ch2", s, cexp(15));
    probe(2, 64'h2, 4, ff, sf, nf, lw, ac);
    read_cnt(2, s, d);
    check("sat_sent_hold", s, cexp(15));

    // cnt_clear overlapping the IDLE->PULSE transition wins.
    pulse_len = 8'd3;
    lnk.hit[4] = 1'b1;
    cnt_clear = 1'b1;
    tick();
    lnk.hit[4] = 1'b0;
    tick();
    cnt_clear = 1'b0;
    tick();
    check("clr_pulse_ran", lnk.coax_out[4], 0);
    read_cnt(4, s, d);
    check("clr_sent_ch4", s, 0);
    check("clr_drop_ch4", d, 0);

    // Async reset in the middle of a pulse.
    pulse_len = 8'd8;
    lnk.hit[7] = 1'b1;
    tick();
    lnk.hit[7] = 1'b0;
    tick();
    tick();
    check("rstmid_pulse_low", lnk.coax_out[7], 0);
    #2;
    nrst = 1'b0;
    #1;
    check("rstmid_coax", lnk.coax_out, 16'hFFFF);
    check("rstmid_tx_active", lnk.tx_active, 0);
    tick();
    nrst = 1'b1;
    pulse_len = 8'd2;
    probe(7, 64'h2, 8, ff, sf, nf, lw, ac);
    check("rstmid_after_fall", ff, 3);
    check("rstmid_after_low", lw, 2);
    read_cnt(7, s, d);
    check("rstmid_sent_ch7", s, cexp(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
